// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl
//   Arbitrates between two requesters (A/B) and sequences an external
//   digit-serial binary-to-BCD converter.
//   The converter needs 3 cycles of settling for the top digit. It needs
//   4 cycles between later digits. The block walks it through 8 digits,
//   most significant first, and collects them in a shadow register.
//   It then publishes the full result atomically with a one-cycle done
//   pulse.
//
// Ports
//   SYS_clk, SYS_rst    clock, async active-high reset
//   req_a/req_b         conversion requests, held until acked
//   bin_a/bin_b [25:0]  operands, valid while the matching req is high
//   ack_a/ack_b         combinational acceptance pulses
//   busy                conversion in progress
//   done, done_id       result-valid pulse and its requester (0=A, 1=B)
//   bcd_out [31:0]      packed BCD result, digit 7 in bits [31:28]
//   blank [7:0]         leading-zero mask; bit 0 is never set
//   cvt_bin_en          converter start pulse
//   cvt_bin_in [25:0]   operand held for the converter
//   cvt_next            converter step-to-next-digit pulse
//   cvt_dec [3:0]       current digit from the converter
module bcd_seq_ctrl (
  input  logic        SYS_clk,
  input  logic        SYS_rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [25:0] bin_a,
  input  logic [25:0] bin_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [31:0] bcd_out,
  output logic [7:0]  blank,
  output logic        cvt_bin_en,
  output logic [25:0] cvt_bin_in,
  output logic        cvt_next,
  input  logic [3:0]  cvt_dec
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPT} state_t;

  state_t      state, state_nx;
  logic [2:0]  dig_idx;
  logic [2:0]  wait_cnt;
  logic        prio_b;     // 1: B wins a tie (A was served last)
  logic        cur_id;     // requester of the conversion in flight
  logic [31:0] shadow;
  logic        grant_a, grant_b, accept;

  // Bit k is set when digit k and every higher digit are zero.
  // A zero result still shows its units digit, so bit 0 stays clear.
  function automatic logic [7:0] blank_mask(input logic [31:0] v);
    logic z;
    blank_mask = 8'h00;
    z = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      z = z & (v[4*k +: 4] == 4'd0);
      blank_mask[k] = z;
    end
  endfunction

  assign grant_a = req_a & (~req_b | ~prio_b);
  assign grant_b = req_b & (~req_a | prio_b);
  assign accept  = (state == S_IDLE) & (req_a | req_b);

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ack_a      = 1'b0;
    ack_b      = 1'b0;
    cvt_bin_en = 1'b0;
    cvt_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          ack_a    = grant_a;
          ack_b    = grant_b;
          state_nx = S_START;
        end
      end
      S_START: begin
        cvt_bin_en = 1'b1;
        state_nx   = S_WAIT;
      end
      // The counter reaches zero on the transition into CAPT.
      S_WAIT: begin
        if (wait_cnt <= 3'd1) state_nx = S_CAPT;
      end
      S_CAPT: begin
        if (dig_idx != 3'd0) begin
          cvt_next = 1'b1;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      bcd_out    <= 32'h0;
      blank      <= 8'hFE;
      cvt_bin_in <= 26'h0;
      dig_idx    <= 3'd7;
      wait_cnt   <= 3'd0;
      prio_b     <= 1'b0;
      cur_id     <= 1'b0;
      shadow     <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cvt_bin_in <= grant_b ? bin_b : bin_a;
            cur_id     <= grant_b;
            prio_b     <= grant_a;
            busy       <= 1'b1;
            dig_idx    <= 3'd7;
          end
        end
        S_START: wait_cnt <= 3'd3;
        S_WAIT:  wait_cnt <= wait_cnt - 3'd1;
        S_CAPT: begin
          shadow[{dig_idx, 2'b00} +: 4] <= cvt_dec;
          if (dig_idx != 3'd0) begin
            dig_idx  <= dig_idx - 3'd1;
            wait_cnt <= 3'd4;
          end else begin
            // The last digit bypasses the shadow, so the whole result lands at once.
            bcd_out <= {shadow[31:4], cvt_dec};
            blank   <= blank_mask({shadow[31:4], cvt_dec});
            done_id <= cur_id;
            done    <= 1'b1;
            busy    <= 1'b0;
            dig_idx <= 3'd7;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
module tb_bcd_seq_ctrl;

  logic        SYS_clk = 1'b0;
  logic        SYS_rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [25:0] bin_a = '0, bin_b = '0;
  logic        ack_a, ack_b, busy, done, done_id;
  logic [31:0] bcd_out;
  logic [7:0]  blank;
  logic        cvt_bin_en, cvt_next;
  logic [25:0] cvt_bin_in;
  logic [3:0]  cvt_dec;

  int nvec = 0;
  int nerr = 0;

  bcd_seq_ctrl dut (
    .SYS_clk(SYS_clk), .SYS_rst(SYS_rst),
    .req_a(req_a), .req_b(req_b), .bin_a(bin_a), .bin_b(bin_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy), .done(done), .done_id(done_id),
    .bcd_out(bcd_out), .blank(blank),
    .cvt_bin_en(cvt_bin_en), .cvt_bin_in(cvt_bin_in),
    .cvt_next(cvt_next), .cvt_dec(cvt_dec)
  );

  always #5 SYS_clk = ~SYS_clk;

  // Converter: presents decimal digit 'ptr' of the held operand.
  int ptr;
  function automatic logic [3:0] dec_digit(input logic [25:0] v, input int k);
    int q;
    q = int'(v);
    for (int i = 0; i < k; i++) q = q / 10;
    return 4'(q % 10);
  endfunction

  always @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst)         ptr <= 7;
    else if (cvt_bin_en) ptr <= 7;
    else if (cvt_next)   ptr <= ptr - 1;
  end
  assign cvt_dec = dec_digit(cvt_bin_in, (ptr < 0) ? 0 : ptr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle invariants and hold checks.
  logic [31:0] hold_bcd;
  logic [7:0]  hold_blank;
  logic [25:0] prev_bin;
  logic        prev_busy;
  int          n_en, n_nx;

  always @(negedge SYS_clk) begin
    if (SYS_rst) begin
      hold_bcd = 32'h0; hold_blank = 8'hFE;
      n_en = 0; n_nx = 0; prev_busy = 1'b0; prev_bin = '0;
    end else begin
      chk("en_next_excl", {31'b0, cvt_bin_en & cvt_next}, 32'h0);
      if (busy && prev_busy) chk("bin_in_stable", {6'b0, cvt_bin_in}, {6'b0, prev_bin});
      if (cvt_bin_en) n_en++;
      if (cvt_next)   n_nx++;
      if (done) begin
        chk("en_pulses", n_en, 1);
        chk("next_pulses", n_nx, 7);
        hold_bcd = bcd_out; hold_blank = blank;
        n_en = 0; n_nx = 0;
      end else begin
        chk("bcd_hold", bcd_out, hold_bcd);
        chk("blank_hold", {24'b0, blank}, {24'b0, hold_blank});
      end
      prev_busy = busy;
      prev_bin  = cvt_bin_in;
    end
  end

  // Raise requests and wait (bounded) for an acceptance cycle.
  task automatic raise(input logic a, input logic b);
    int waited;
    @(posedge SYS_clk); #1;
    if (a) req_a = 1'b1;
    if (b) req_b = 1'b1;
    waited = 0;
    @(negedge SYS_clk);
    while (!(ack_a || ack_b) && waited < 100) begin
      @(negedge SYS_clk);
      waited++;
    end
    if (waited >= 100) chk("ack_timeout", 32'd1, 32'd0);
  endtask

  // Called at the acceptance negedge; returns at the done negedge.
  task automatic wait_done(input logic drop_a, input logic drop_b, output int lat);
    @(posedge SYS_clk); #1;
    if (drop_a) req_a = 1'b0;
    if (drop_b) req_b = 1'b0;
    lat = 1;
    @(negedge SYS_clk);
    chk("busy_set", {31'b0, busy}, 32'd1);
    while (!done && lat < 100) begin
      @(negedge SYS_clk);
      lat++;
    end
    chk("latency", lat, 41);
    chk("busy_clr", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        sel_b;
    logic [25:0] bin;
    logic [31:0] exp_bcd;
    logic [7:0]  exp_blank;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lat;
    if (v.sel_b) bin_b = v.bin; else bin_a = v.bin;
    raise(!v.sel_b, v.sel_b);
    chk("ack_a", {31'b0, ack_a}, {31'b0, !v.sel_b});
    chk("ack_b", {31'b0, ack_b}, {31'b0, v.sel_b});
    wait_done(1'b1, 1'b1, lat);
    chk("bcd_out", bcd_out, v.exp_bcd);
    chk("blank", {24'b0, blank}, {24'b0, v.exp_blank});
    chk("done_id", {31'b0, done_id}, {31'b0, v.sel_b});
  endtask

  vec_t vt[8];

  initial begin
    int lat, early, k, nd;
    vt[0] = '{1'b0, 26'd12345678, 32'h12345678, 8'h00};
    vt[1] = '{1'b1, 26'd0,        32'h00000000, 8'hFE};
    vt[2] = '{1'b0, 26'd67108863, 32'h67108863, 8'h00};
    vt[3] = '{1'b0, 26'd905,      32'h00000905, 8'hF8};
    vt[4] = '{1'b1, 26'd10000000, 32'h10000000, 8'h00};
    vt[5] = '{1'b1, 26'd7,        32'h00000007, 8'hFE};
    vt[6] = '{1'b0, 26'd40,       32'h00000040, 8'hFC};
    vt[7] = '{1'b1, 26'd1000,     32'h00001000, 8'hF0};

    // Reset state
    #2 SYS_rst = 1'b1;
    @(negedge SYS_clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_done_id", {31'b0, done_id}, 32'd0);
    chk("rst_bcd", bcd_out, 32'h0);
    chk("rst_blank", {24'b0, blank}, 32'hFE);
    chk("rst_bin_in", {6'b0, cvt_bin_in}, 32'h0);
    chk("rst_en", {31'b0, cvt_bin_en}, 32'd0);
    chk("rst_next", {31'b0, cvt_next}, 32'd0);
    @(posedge SYS_clk); #1 SYS_rst = 1'b0;

    // Simultaneous requests from reset: A first, B taken in A's done cycle
    for (int r = 0; r < 2; r++) begin
      bin_a = 26'd111; bin_b = 26'd222;
      raise(1'b1, 1'b1);
      chk("tie_ack_a", {31'b0, ack_a}, 32'd1);
      chk("tie_ack_b", {31'b0, ack_b}, 32'd0);
      wait_done(1'b1, 1'b0, lat);
      chk("tie_id0", {31'b0, done_id}, 32'd0);
      chk("tie_bcd_a", bcd_out, 32'h00000111);
      chk("tie_ack_b_done", {31'b0, ack_b}, 32'd1);
      wait_done(1'b0, 1'b1, lat);
      chk("tie_id1", {31'b0, done_id}, 32'd1);
      chk("tie_bcd_b", bcd_out, 32'h00000222);
    end

    // B requests while A is busy: held off until A's done cycle
    bin_a = 26'd4321;
    raise(1'b1, 1'b0);
    chk("busy_ack_a", {31'b0, ack_a}, 32'd1);
    @(posedge SYS_clk); #1 req_a = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge SYS_clk);
    #1 bin_b = 26'd8765; req_b = 1'b1;
    early = 0; k = 0;
    while (k < 100) begin
      @(negedge SYS_clk);
      k++;
      if (done) break;
      if (ack_b) early++;
    end
    chk("busy_no_ack_b", early, 0);
    chk("busy_done_seen", {31'b0, done}, 32'd1);
    chk("busy_ack_b_done", {31'b0, ack_b}, 32'd1);
    chk("busy_bcd_a", bcd_out, 32'h00004321);
    wait_done(1'b0, 1'b1, lat);
    chk("busy_bcd_b", bcd_out, 32'h00008765);
    chk("busy_id_b", {31'b0, done_id}, 32'd1);

    // Table of single-requester conversions
    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Reset in the middle of a conversion
    bin_a = 26'd55555555;
    raise(1'b1, 1'b0);
    @(posedge SYS_clk); #1 req_a = 1'b0;
    for (int i = 0; i < 19; i++) @(posedge SYS_clk);
    #2 SYS_rst = 1'b1;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_done_id", {31'b0, done_id}, 32'd0);
    chk("mid_bcd", bcd_out, 32'h0);
    chk("mid_blank", {24'b0, blank}, 32'hFE);
    chk("mid_bin_in", {6'b0, cvt_bin_in}, 32'h0);
    chk("mid_en", {31'b0, cvt_bin_en}, 32'd0);
    chk("mid_next", {31'b0, cvt_next}, 32'd0);
    @(posedge SYS_clk); #1 SYS_rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge SYS_clk);
      if (done) nd++;
    end
    chk("mid_no_done", nd, 0);
    run_vec('{1'b0, 26'd24680135, 32'h24680135, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
